// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and NOP-bubble control.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer with a registered in_ready_o.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_a_i,
  input  logic [DATA_W-1:0] data_b_i,
  input  logic [REG_W-1:0]  dst_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_a_o,
  output logic [DATA_W-1:0] data_b_o,
  output logic [REG_W-1:0]  dst_o
);

  logic              valid_q,  valid_d;
  logic [CTRL_W-1:0] ctrl_q,   ctrl_d;
  logic [DATA_W-1:0] data_a_q, data_a_d;
  logic [DATA_W-1:0] data_b_q, data_b_d;
  logic [REG_W-1:0]  dst_q,    dst_d;
  logic              accept;
  logic              retire;

  assign retire = valid_q & out_ready_i;

`ifdef PIPE_STAGE_SKID_EN
  logic              rdy_q,       rdy_d;
  logic              skid_full_q, skid_full_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_a_q,    skid_a_d;
  logic [DATA_W-1:0] skid_b_q,    skid_b_d;
  logic [REG_W-1:0]  skid_dst_q,  skid_dst_d;

  // Ready comes straight from a flop: no path from out_ready_i.
  assign in_ready_o = rdy_q;
  assign accept     = in_valid_i & rdy_q;

  always_comb begin
    valid_d     = valid_q;
    ctrl_d      = ctrl_q;
    data_a_d    = data_a_q;
    data_b_d    = data_b_q;
    dst_d       = dst_q;
    skid_full_d = skid_full_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_a_d    = skid_a_q;
    skid_b_d    = skid_b_q;
    skid_dst_d  = skid_dst_q;
    if (flush_i) begin
      valid_d     = 1'b0;
      ctrl_d      = '0;
      skid_full_d = 1'b0;
    end else if (skid_full_q) begin
      if (retire) begin
        valid_d     = 1'b1;
        ctrl_d      = skid_ctrl_q;
        data_a_d    = skid_a_q;
        data_b_d    = skid_b_q;
        dst_d       = skid_dst_q;
        skid_full_d = 1'b0;
      end
    end else if (accept) begin
      if (!valid_q || out_ready_i) begin
        valid_d  = 1'b1;
        ctrl_d   = ctrl_i;
        data_a_d = data_a_i;
        data_b_d = data_b_i;
        dst_d    = dst_i;
      end else begin
        skid_full_d = 1'b1;
        skid_ctrl_d = ctrl_i;
        skid_a_d    = data_a_i;
        skid_b_d    = data_b_i;
        skid_dst_d  = dst_i;
      end
    end else if (retire) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
    rdy_d = ~skid_full_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q       <= 1'b1;
      skid_full_q <= 1'b0;
      skid_ctrl_q <= '0;
      skid_a_q    <= '0;
      skid_b_q    <= '0;
      skid_dst_q  <= '0;
    end else begin
      rdy_q       <= rdy_d;
      skid_full_q <= skid_full_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_a_q    <= skid_a_d;
      skid_b_q    <= skid_b_d;
      skid_dst_q  <= skid_dst_d;
    end
  end
`else
  // Backpressure passes straight through: accept whenever the slot frees this edge.
  assign in_ready_o = out_ready_i | ~valid_q;
  assign accept     = in_valid_i & in_ready_o;

  always_comb begin
    valid_d  = valid_q;
    ctrl_d   = ctrl_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    dst_d    = dst_q;
    if (flush_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (accept) begin
      valid_d  = 1'b1;
      ctrl_d   = ctrl_i;
      data_a_d = data_a_i;
      data_b_d = data_b_i;
      dst_d    = dst_i;
    end else if (retire) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end
`endif

  // Output stage; ctrl is cleared whenever the stage empties so it reads as a NOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
      dst_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      dst_q    <= dst_d;
    end
  end

  assign out_valid_o = valid_q;
  assign ctrl_o      = ctrl_q;
  assign data_a_o    = data_a_q;
  assign data_b_o    = data_b_q;
  assign dst_o       = dst_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: default-width and wide (64/8/6) instances
// checked every cycle against a queue-based model, plus directed literal scenarios.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        in_valid_i;
  logic        out_ready_i;
  logic [3:0]  ctrl_i;
  logic [31:0] data_a_i, data_b_i, data_a_hi;
  logic [4:0]  dst_i;

  logic        in_ready_o, out_valid_o;
  logic [3:0]  ctrl_o;
  logic [31:0] data_a_o, data_b_o;
  logic [4:0]  dst_o;

  logic        w_in_ready_o, w_out_valid_o;
  logic [7:0]  w_ctrl_i, w_ctrl_o;
  logic [63:0] w_data_a_i, w_data_b_i, w_data_a_o, w_data_b_o;
  logic [5:0]  w_dst_i, w_dst_o;

  assign w_ctrl_i   = {~ctrl_i, ctrl_i};
  assign w_data_a_i = {data_a_hi, data_a_i};
  assign w_data_b_i = {data_a_i, data_b_i};
  assign w_dst_i    = {dst_i[0], dst_i};

  pipe_stage_reg u_dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .ctrl_i(ctrl_i), .data_a_i(data_a_i), .data_b_i(data_b_i), .dst_i(dst_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .ctrl_o(ctrl_o), .data_a_o(data_a_o), .data_b_o(data_b_o), .dst_o(dst_o)
  );

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .REG_W(6)) u_wide (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(w_in_ready_o),
    .ctrl_i(w_ctrl_i), .data_a_i(w_data_a_i), .data_b_i(w_data_b_i), .dst_i(w_dst_i),
    .out_valid_o(w_out_valid_o), .out_ready_i(out_ready_i),
    .ctrl_o(w_ctrl_o), .data_a_o(w_data_a_o), .data_b_o(w_data_b_o), .dst_o(w_dst_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Model: the stage is a FIFO of capacity 1 (2 with skid); front is what the outputs show.
  typedef struct packed {
    logic [7:0]  ctrl;
    logic [63:0] a;
    logic [63:0] b;
    logic [5:0]  dst;
  } beat_t;

  beat_t q[$];
  beat_t last;

  function automatic bit model_ready();
`ifdef PIPE_STAGE_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || out_ready_i;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      last = '0;
    end else begin
      bit rdy;
      beat_t b;
      rdy = model_ready();
      b   = '{ctrl: w_ctrl_i, a: w_data_a_i, b: w_data_b_i, dst: w_dst_i};
      if (flush_i) q.delete();
      else begin
        if (q.size() > 0 && out_ready_i) void'(q.pop_front());
        if (in_valid_i && rdy) q.push_back(b);
      end
      if (q.size() > 0) last = q[0];
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    bit v;
    v = q.size() > 0;
    chk("out_valid", 64'(out_valid_o), 64'(v));
    chk("ctrl",      64'(ctrl_o),      v ? 64'(last.ctrl[3:0]) : 64'd0);
    chk("data_a",    64'(data_a_o),    64'(last.a[31:0]));
    chk("data_b",    64'(data_b_o),    64'(last.b[31:0]));
    chk("dst",       64'(dst_o),       64'(last.dst[4:0]));
    chk("in_ready",  64'(in_ready_o),  64'(model_ready()));
    chk("w_out_valid", 64'(w_out_valid_o), 64'(v));
    chk("w_ctrl",      64'(w_ctrl_o),      v ? 64'(last.ctrl) : 64'd0);
    chk("w_data_a",    w_data_a_o,         last.a);
    chk("w_data_b",    w_data_b_o,         last.b);
    chk("w_dst",       64'(w_dst_o),       64'(last.dst));
    chk("w_in_ready",  64'(w_in_ready_o),  64'(model_ready()));
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [3:0] c);
    in_valid_i = v;
    data_a_i   = a;
    data_b_i   = ~a;
    ctrl_i     = c;
    dst_i      = a[4:0];
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; out_ready_i = 1'b1; data_a_hi = '0;
    drive(1'b1, 32'hDEAD_BEEF, 4'hF);
    // Reset holds everything at zero despite active inputs.
    repeat (3) step();
    chk("rst_valid",  64'(out_valid_o), 64'd0);
    chk("rst_ctrl",   64'(ctrl_o),      64'd0);
    chk("rst_data_a", 64'(data_a_o),    64'd0);
    chk("rst_data_b", 64'(data_b_o),    64'd0);
    chk("rst_dst",    64'(dst_o),       64'd0);
    drive(1'b0, 32'd0, 4'h0);
    rst = 1'b0;
    chk("rst_ready", 64'(in_ready_o), 64'd1);
    step();

    // Streaming 1..4 back to back.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(i), 4'b0001);
      step();
      chk("stream_data", 64'(data_a_o),    64'(i));
      chk("stream_valid", 64'(out_valid_o), 64'd1);
    end
    // One-cycle bubble mid-stream.
    drive(1'b0, 32'd0, 4'h0);
    step();
    chk("bubble_valid", 64'(out_valid_o), 64'd0);
    chk("bubble_ctrl",  64'(ctrl_o),      64'd0);
    chk("bubble_hold",  64'(data_a_o),    64'd4);
    drive(1'b1, 32'd5, 4'b0011);
    step();
    chk("after_bubble", 64'(data_a_o), 64'd5);
    drive(1'b0, 32'd0, 4'h0);
    step();

    // Stall: A held three cycles while B waits.
    out_ready_i = 1'b0;
    drive(1'b1, 32'h10, 4'b0101);
    step();
    chk("stall_a_out", 64'(data_a_o), 64'h10);
    drive(1'b1, 32'h20, 4'b0110);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_hold", 64'(data_a_o), 64'h10);
`ifdef PIPE_STAGE_SKID_EN
      chk("stall_skid_ready", 64'(in_ready_o), 64'd0);
`else
      chk("stall_ready", 64'(in_ready_o), 64'd0);
`endif
    end
    out_ready_i = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
    in_valid_i = 1'b0;
`endif
    step();
    chk("release_b", 64'(data_a_o), 64'h20);
    chk("release_valid", 64'(out_valid_o), 64'd1);
    drive(1'b0, 32'd0, 4'h0);
    step();
    chk("drained", 64'(out_valid_o), 64'd0);

    // Flush kills the held beat and the beat offered in the same cycle.
    out_ready_i = 1'b0;
    drive(1'b1, 32'h30, 4'b1011);
    step();
    chk("flush_pre_ctrl", 64'(ctrl_o), 64'hB);
    out_ready_i = 1'b1;
    flush_i = 1'b1;
    drive(1'b1, 32'h40, 4'b1100);
    step();
    chk("flush_valid", 64'(out_valid_o), 64'd0);
    chk("flush_ctrl",  64'(ctrl_o),      64'd0);
    flush_i = 1'b0;
    drive(1'b0, 32'd0, 4'h0);
    step();
    chk("flush_absent", 64'(out_valid_o), 64'd0);

    // Wide instance reproduces a 64-bit payload bit-exact.
    data_a_hi = 32'hFFFF_0000;
    drive(1'b1, 32'h1234_5678, 4'b0001);
    step();
    chk("wide_data", w_data_a_o, 64'hFFFF_0000_1234_5678);
    drive(1'b0, 32'd0, 4'h0);
    step();

    // Reset during a stall loses the held beat.
    out_ready_i = 1'b0;
    drive(1'b1, 32'h55, 4'b0111);
    step();
    drive(1'b0, 32'd0, 4'h0);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(out_valid_o), 64'd0);
    rst = 1'b0;
    out_ready_i = 1'b1;
    repeat (2) begin
      step();
      chk("midrst_nobeat", 64'(out_valid_o), 64'd0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      in_valid_i  = $urandom_range(0, 3) != 0;
      out_ready_i = $urandom_range(0, 3) != 0;
      flush_i     = $urandom_range(0, 19) == 0;
      data_a_i    = $urandom;
      data_b_i    = $urandom;
      data_a_hi   = $urandom;
      ctrl_i      = 4'($urandom);
      dst_i       = 5'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of each data payload field (ALU result, store data).
REQ-002 SHALL have parameter CTRL_W, default 4, width of the control bundle (e.g. RegWrite, MemtoReg, MemRead, MemWrite).
REQ-003 SHALL have parameter REG_W, default 5, width of the destination register index.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port flush_i  input  1  squash the stage contents (branch/exception kill).
REQ-007 SHALL have port in_valid_i  input  1  upstream beat present.
REQ-008 SHALL have port in_ready_o  output  1  stage can accept a beat this cycle.
REQ-009 SHALL have port ctrl_i  input  CTRL_W  upstream control bundle.
REQ-010 SHALL have ports data_a_i, data_b_i  input  DATA_W  upstream payloads (ALU result, rt/store data).
REQ-011 SHALL have port dst_i  input  REG_W  upstream destination register index.
REQ-012 SHALL have port out_valid_o  output  1  stage holds a valid beat.
REQ-013 SHALL have port out_ready_i  input  1  downstream accepts the beat this cycle.
REQ-014 SHALL have ports ctrl_o (CTRL_W), data_a_o, data_b_o (DATA_W), dst_o (REG_W)  output  registered beat fields.

Function
REQ-015 SHALL accept a beat on a rising edge where in_valid_i=1 and in_ready_o=1, and present it on the outputs with out_valid_o=1 in the following cycle (latency 1).
REQ-016 SHALL retire the output beat on a rising edge where out_valid_o=1 and out_ready_i=1.
REQ-017 SHALL hold all outputs stable while out_valid_o=1 and out_ready_i=0 (stall).
REQ-018 SHALL sustain one beat per cycle when in_valid_i=1 and out_ready_i=1 continuously, preserving beat order with no loss or duplication.
REQ-019 SHALL drive ctrl_o to all-zero whenever out_valid_o=0, so an empty stage is a NOP bubble; data_a_o, data_b_o, dst_o retain their last values.
REQ-020 SHALL, when flush_i=1 at a rising edge, set out_valid_o=0, ctrl_o=0 and discard every stored beat (including any skid entry) in the next cycle.
REQ-021 SHALL give flush_i priority over a simultaneous input transfer: a beat handshaken in the flush cycle is dropped.
REQ-022 SHALL keep in_ready_o independent of flush_i.

Reset
REQ-023 SHALL, while rst=1, asynchronously force out_valid_o=0, ctrl_o=0, data_a_o=0, data_b_o=0, dst_o=0 and empty the skid entry.
REQ-024 SHALL drive in_ready_o=1 in the first cycle after rst deasserts.
REQ-025 SHALL, on rst asserted mid-stall, lose the held beat; no beat is emitted after release until a new input transfer.

Configuration
REQ-026 SHALL use macro PIPE_STAGE_SKID_EN to select the ready-path structure.
REQ-027 SHALL, without PIPE_STAGE_SKID_EN, drive in_ready_o = out_ready_i OR NOT out_valid_o (combinational pass-through of backpressure).
REQ-028 SHALL, with PIPE_STAGE_SKID_EN, add a one-entry skid buffer and drive in_ready_o from a flop equal to NOT skid_full, with no combinational path from out_ready_i to in_ready_o.
REQ-029 SHALL, with PIPE_STAGE_SKID_EN, capture an accepted beat into the skid entry when the output is valid and not retired that cycle, and move it to the output on the next retire edge; latency and order unchanged when not stalled.

Verification
REQ-030 SHALL cover reset: rst=1 with inputs data_a_i=0xDEADBEEF, ctrl_i=4'hF -> all outputs 0, out_valid_o=0; after release in_ready_o=1.
REQ-031 SHALL cover streaming: beats data_a_i=1,2,3,4 on consecutive cycles, out_ready_i=1 -> data_a_o=1,2,3,4 on the following 4 cycles, out_valid_o=1 throughout.
REQ-032 SHALL cover stall: beat A=0x10 at output, out_ready_i=0 for 3 cycles -> data_a_o=0x10 held 3 cycles; in skid build, beat B=0x20 accepted once, then in_ready_o=0; on release A then B emitted.
REQ-033 SHALL cover flush: flush_i=1 with out_valid_o=1, ctrl_o=4'b1011 and in_valid_i=1 -> next cycle out_valid_o=0, ctrl_o=0, incoming beat absent from output.
REQ-034 SHALL cover bubble: in_valid_i=0 for one cycle mid-stream -> exactly one cycle of out_valid_o=0 with ctrl_o=0.
REQ-035 SHALL cover parameters: DATA_W=64, CTRL_W=8, REG_W=6 build passes REQ-031 with data_a_i=64'hFFFF_0000_1234_5678 reproduced bit-exact.
